// File: rtl/counter_pkg.sv
// Shared definitions for the lab counter datapath (up-counter and down timer).
package counter_pkg;

    // Default datapath width shared by the up-counter and the down timer.
    localparam int CNT_WIDTH = 5;

    // Timer sequencing states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        EXPIRED = 2'd2
    } timer_state_t;

endpackage

// File: rtl/tc_event_latch.sv
// Sticky terminal-count event flag with overrun detection.
// A new event always beats a same-cycle acknowledge, so nothing is lost.
module tc_event_latch (
    input  logic CLK,
    input  logic RST,
    input  logic TC_SET,
    input  logic ACK,
    output logic DONE,
    output logic OVERRUN
);

    logic done_q, done_d;
    logic ovr_q, ovr_d;

    // Next-state: set has priority over the acknowledge clear.
    always_comb begin
        done_d = done_q;
        ovr_d  = ovr_q;
        if (TC_SET) begin
            done_d = 1'b1;
        end else if (ACK) begin
            done_d = 1'b0;
        end
        // Overrun: a second event lands while the first is still unacknowledged.
        if (TC_SET && done_q && !ACK) begin
            ovr_d = 1'b1;
        end else if (ACK) begin
            ovr_d = 1'b0;
        end
    end

    // Flag registers, cleared asynchronously.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            done_q <= 1'b0;
            ovr_q  <= 1'b0;
        end else begin
            done_q <= done_d;
            ovr_q  <= ovr_d;
        end
    end

    assign DONE    = done_q;
    assign OVERRUN = ovr_q;

endmodule

// File: rtl/down_counter_timer.sv
// Loadable down-counting interval timer: one-shot or periodic (auto-reload),
// one-cycle TC pulse, sticky DONE/OVERRUN event flags. All outputs registered.
module down_counter_timer
    import counter_pkg::*;
#(
    parameter int WIDTH = CNT_WIDTH
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ENA,
    input  logic             LOAD,
    input  logic             MODE,
    input  logic [WIDTH-1:0] DATA,
    input  logic             ACK,
    output logic [WIDTH-1:0] COUNT,
    output logic             TC,
    output logic             DONE,
    output logic             OVERRUN,
    output logic             BUSY
);

    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             mode_q, mode_d;
    timer_state_t     state_q, state_d;
    logic             tc_q, tc_d;
    logic             busy_q, busy_d;

    // Counter/FSM next-state: load beats counting, ENA=0 freezes everything.
    always_comb begin
        count_d  = count_q;
        reload_d = reload_q;
        mode_d   = mode_q;
        state_d  = state_q;
        tc_d     = 1'b0;
        if (ENA && LOAD) begin
            count_d  = DATA;
            reload_d = DATA;
            mode_d   = MODE;
            state_d  = (DATA != '0) ? RUN : IDLE;
        end else if (ENA) begin
            case (state_q)
                RUN: begin
                    // RUN is only entered with a non-zero count, so the
                    // decrement never wraps.
                    if (count_q == WIDTH'(1)) begin
                        tc_d = 1'b1;
                        if (mode_q) begin
                            // Periodic: skip the 0 state so the period is exactly reload_q.
                            count_d = reload_q;
                        end else begin
                            count_d = '0;
                            state_d = EXPIRED;
                        end
                    end else begin
                        count_d = count_q - WIDTH'(1);
                    end
                end
                EXPIRED: begin
                    if (ACK) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                end
            endcase
        end
        busy_d = (state_d == RUN);
    end

    // Counter, reload, mode, state and pulse registers.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            count_q  <= '0;
            reload_q <= '0;
            mode_q   <= 1'b0;
            state_q  <= IDLE;
            tc_q     <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            count_q  <= count_d;
            reload_q <= reload_d;
            mode_q   <= mode_d;
            state_q  <= state_d;
            tc_q     <= tc_d;
            busy_q   <= busy_d;
        end
    end

    tc_event_latch u_evt (
        .CLK     (CLK),
        .RST     (RST),
        .TC_SET  (tc_d),
        .ACK     (ACK),
        .DONE    (DONE),
        .OVERRUN (OVERRUN)
    );

    assign COUNT = count_q;
    assign TC    = tc_q;
    assign BUSY  = busy_q;

endmodule
